ps2_gpio_source: RTL and testbench
==================================

# ps2_gpio_source

Receives scan-code bytes from a PS/2 keyboard and queues them in a small FIFO. It presents the queued bytes to the CPU core on an 8-bit GPIO input port, plus a status byte. This is the input-direction counterpart of the CPU's GPIO-to-text-display output path. The CPU consumes bytes with an edge-triggered acknowledge on a GPIO output line, which keeps the block correct when the CPU runs on the single-step clock.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries; power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops on every asynchronous input
- TIMEOUT_CYCLES, 50000, clk cycles without a PS2_CLK falling edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  reset; synchronous, active-low
- PS2_CLK  in  1  raw keyboard clock (asynchronous, idle high)
- PS2_DAT  in  1  raw keyboard data (asynchronous, idle high)
- GPIO_CTRL  in  8  from CPU: bit0 = ack/pop (rising edge), bit1 = clear sticky errors (rising edge), bits 7:2 ignored
- GPIO_DATA  out  8  FIFO head byte; 0x00 when empty
- GPIO_STAT  out  8  bit0 = valid (FIFO non-empty), bit1 = overflow (sticky), bit2 = frame error (sticky), bits 5:3 = occupancy 0..FIFO_DEPTH, bits 7:6 = 0

## Operation
- All async inputs pass through SYNC_STAGES flops.
  - PS2 synchronizer flops reset to 1.
  - GPIO_CTRL synchronizer and edge-history flops reset to 1, so a line held high through reset produces no edge.
- Receiver FSM:
  - IDLE: on a PS2_CLK falling edge, sample PS2_DAT as bit 0, go to SHIFT.
  - SHIFT: sample PS2_DAT on each falling edge. After the 11th bit, go to CHECK.
  - CHECK (1 cycle): the frame is good if start = 0, stop = 1, and data+parity has an odd number of ones.
    - Good frame: push the data byte (LSB-first assembly). If the FIFO is full, drop the byte and set overflow.
    - Bad frame: set frame error, no push.
    - Return to IDLE.
  - SHIFT timeout: an idle counter clears on every falling edge. When it reaches TIMEOUT_CYCLES, set frame error and return to IDLE.
- Pop: a rising edge on the synced GPIO_CTRL[0] removes the head entry. A pop on an empty FIFO is ignored.
- Push and pop in the same cycle:
  - Both happen and occupancy is unchanged.
  - If the FIFO is full, the pop frees space first; the push is accepted and overflow is not set.
- Clear: a rising edge on the synced GPIO_CTRL[1] clears overflow and frame error. If a set event occurs in the same cycle, the set wins.
- Reset:
  - FIFO empty, FSM IDLE, counters 0, sticky bits 0.
  - GPIO_DATA = 0x00, GPIO_STAT = 0x00.
  - A frame in progress at reset is discarded.
- Arithmetic widths:
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - Occupancy is log2(FIFO_DEPTH)+1 bits, zero-extended into STAT[5:3].
  - The timeout counter is wide enough for TIMEOUT_CYCLES and saturates.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 cycles for PS2_CLK edges and GPIO_CTRL edges.
- Push happens in the CHECK cycle, which immediately follows detection of the 11th falling edge.
- GPIO_DATA and GPIO_STAT are registered. They reflect FIFO state one cycle after any push, pop or flag change.
- Ack round trip: GPIO_CTRL[0] rising at the pin, then GPIO_DATA shows the next entry (or 0x00) SYNC_STAGES+2 cycles later.
- One pop per rising edge, regardless of how long the CPU holds bit0 high.

## Structure
- Package ps2_gpio_pkg holds:
  - the FSM state enum (IDLE, SHIFT, CHECK)
  - STAT bit indices (STAT_VALID=0, STAT_OVF=1, STAT_FERR=2, STAT_CNT_LSB=3)
  - frame bit positions (START=0, PARITY=9, STOP=10)
- One sub-module, byte_fifo: parameterized depth, 8-bit data, push/pop/full/empty/count, with the simultaneous push/pop-when-full rule built in.
- The synchronizers, edge detectors and receiver FSM stay in the top module.

## Test plan
- After reset, send frame 0x1C (parity 0) → GPIO_DATA=0x1C, GPIO_STAT=0x09.
- From that state, raise GPIO_CTRL[0] → after SYNC_STAGES+2 cycles, GPIO_DATA=0x00, GPIO_STAT=0x00. Holding bit0 high causes no further pops.
- Send 0x01..0x05 with no ack → GPIO_STAT=0x23 and GPIO_DATA=0x01. A clear edge gives STAT=0x21. Four acks read 0x01, 0x02, 0x03, 0x04.
- Send 0xF0 with parity bit 0 (wrong) → no push, GPIO_STAT=0x04. Then send a good 0xF0 (parity 1) → GPIO_STAT=0x0D, GPIO_DATA=0xF0.
- Send 5 clock pulses, then hold PS2_CLK high for TIMEOUT_CYCLES → FERR set, FSM back in IDLE. A following good 0x2A frame is received correctly.
- Full FIFO plus a last-stop-edge push aligned with an ack pop in the same cycle → occupancy stays 4, OVF stays 0, new byte at tail. Separately, drive rst low mid-frame → next cycle all outputs 0x00, and the next full frame is received cleanly.

Source files
------------

// File: rtl/ps2_gpio_source_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and its GPIO view.
package ps2_gpio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  localparam int STAT_VALID   = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_FERR    = 2;
  localparam int STAT_CNT_LSB = 3;

  localparam int START      = 0;
  localparam int PARITY     = 9;
  localparam int STOP       = 10;
  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/ps2_gpio_source_if.sv
// Pin bundle between the keyboard/CPU side and the receiver block.
interface ps2_gpio_source_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] GPIO_CTRL;
  logic [7:0] GPIO_DATA;
  logic [7:0] GPIO_STAT;

  modport master (output PS2_CLK, PS2_DAT, GPIO_CTRL, input GPIO_DATA, GPIO_STAT);
  modport slave  (input PS2_CLK, PS2_DAT, GPIO_CTRL, output GPIO_DATA, GPIO_STAT);
endinterface

// File: rtl/ps2_gpio_source_byte_fifo.sv
// Byte FIFO; a pop in the same cycle frees room so a push into a full FIFO is accepted.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ps2_gpio_source.sv
// PS/2 keyboard receiver feeding a byte FIFO that the CPU reads through GPIO.
module ps2_gpio_source
  import ps2_gpio_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clk,
  input logic              rst,
  ps2_gpio_source_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] pclk_sync_q, pdat_sync_q, ack_sync_q, clr_sync_q;
  logic                   pclk_prev_q, ack_prev_q, clr_prev_q;
  logic                   pclk_fall, pdat, ack_rise, clr_rise;
  logic                   unused_ctrl;

  rx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   push_req, frame_bad, timeout, frame_ok;

  logic                   ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]             data_q, stat_q, stat_d;
  logic [7:0]             fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  assign unused_ctrl = &{1'b0, bus.GPIO_CTRL[7:2]};

  // Sync and edge-history flops reset high so lines idling high give no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pclk_sync_q <= '1;
      pdat_sync_q <= '1;
      ack_sync_q  <= '1;
      clr_sync_q  <= '1;
      pclk_prev_q <= 1'b1;
      ack_prev_q  <= 1'b1;
      clr_prev_q  <= 1'b1;
    end else begin
      pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], bus.PS2_CLK};
      pdat_sync_q <= {pdat_sync_q[SYNC_STAGES-2:0], bus.PS2_DAT};
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], bus.GPIO_CTRL[0]};
      clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], bus.GPIO_CTRL[1]};
      pclk_prev_q <= pclk_sync_q[SYNC_STAGES-1];
      ack_prev_q  <= ack_sync_q[SYNC_STAGES-1];
      clr_prev_q  <= clr_sync_q[SYNC_STAGES-1];
    end
  end

  assign pclk_fall = pclk_prev_q & ~pclk_sync_q[SYNC_STAGES-1];
  assign pdat      = pdat_sync_q[SYNC_STAGES-1];
  assign ack_rise  = ~ack_prev_q & ack_sync_q[SYNC_STAGES-1];
  assign clr_rise  = ~clr_prev_q & clr_sync_q[SYNC_STAGES-1];

  assign frame_ok = ~shift_q[START] & shift_q[STOP] & (^shift_q[PARITY:1]);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcnt_d    = bcnt_q;
    to_cnt_d  = to_cnt_q;
    push_req  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (pclk_fall) begin
          shift_d = {pdat, shift_q[FRAME_BITS-1:1]};
          bcnt_d  = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (pclk_fall) begin
          shift_d  = {pdat, shift_q[FRAME_BITS-1:1]};
          to_cnt_d = '0;
          bcnt_d   = bcnt_q + 4'd1;
          if (bcnt_q == 4'(FRAME_BITS - 1)) state_d = CHECK;
        end else if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          timeout  = 1'b1;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        push_req  = frame_ok;
        frame_bad = ~frame_ok;
        bcnt_d    = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear; a push into a full FIFO only overflows if no pop frees room.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (clr_rise) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (push_req & fifo_full & ~ack_rise) ovf_d  = 1'b1;
    if (frame_bad | timeout)              ferr_d = 1'b1;
  end

  always_comb begin
    stat_d                                   = '0;
    stat_d[STAT_VALID]                       = ~fifo_empty;
    stat_d[STAT_OVF]                         = ovf_q;
    stat_d[STAT_FERR]                        = ferr_q;
    stat_d[STAT_CNT_LSB+2:STAT_CNT_LSB]      = 3'(fifo_count);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      to_cnt_q <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      to_cnt_q <= to_cnt_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      data_q   <= fifo_empty ? 8'h00 : fifo_head;
      stat_q   <= stat_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  (shift_q[8:1]),
    .pop_i   (ack_rise),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.GPIO_DATA = data_q;
  assign bus.GPIO_STAT = stat_q;
endmodule

// File: tb/tb_ps2_gpio_source.sv
// Directed plus random frames against a queue-based model of the receiver/FIFO.
module tb_ps2_gpio_source;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mq [$];
  bit         m_ovf = 0;
  bit         m_ferr = 0;

  ps2_gpio_source_if bus ();

  ps2_gpio_source #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  function automatic logic [7:0] m_stat();
    logic [7:0] s;
    s      = 8'h00;
    s[0]   = (mq.size() != 0);
    s[1]   = m_ovf;
    s[2]   = m_ferr;
    s[5:3] = 3'(mq.size());
    return s;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_data"}, bus.GPIO_DATA, m_head());
    chk({tag, "_stat"}, bus.GPIO_STAT, m_stat());
  endtask

  // Drives nbits of an 11-bit frame; optionally raises ack one cycle after the last fall.
  task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits,
                           input bit ack_last);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_DAT = fr[i];
      tick(HALF);
      bus.PS2_CLK = 1'b0;
      if (ack_last && i == nbits - 1) begin
        tick(1);
        bus.GPIO_CTRL[0] = 1'b1;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    send_bits(d, bad_par, 11, 1'b0);
    if (bad_par) m_ferr = 1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1;
  endtask

  task automatic ack(input string tag);
    logic [7:0] old_head;
    old_head = m_head();
    bus.GPIO_CTRL[0] = 1'b1;
    if (mq.size() != 0) void'(mq.pop_front());
    tick(SYNC + 1);
    chk({tag, "_early"}, bus.GPIO_DATA, old_head);
    tick(1);
    chk_all({tag, "_rt"});
    tick(10);
    chk_all({tag, "_hold"});
    bus.GPIO_CTRL[0] = 1'b0;
    tick(SYNC + 3);
  endtask

  task automatic clear_flags();
    bus.GPIO_CTRL[1] = 1'b1;
    tick(6);
    bus.GPIO_CTRL[1] = 1'b0;
    tick(4);
    m_ovf  = 0;
    m_ferr = 0;
  endtask

  initial begin
    logic [7:0] rb;
    bus.PS2_CLK   = 1'b1;
    bus.PS2_DAT   = 1'b1;
    bus.GPIO_CTRL = 8'h00;
    tick(4);
    rst = 1'b1;
    tick(2);
    chk("reset_data", bus.GPIO_DATA, 8'h00);
    chk("reset_stat", bus.GPIO_STAT, 8'h00);

    send_frame(8'h1C, 1'b0);
    chk("f1c_data", bus.GPIO_DATA, 8'h1C);
    chk("f1c_stat", bus.GPIO_STAT, 8'h09);
    ack("ack1c");
    chk("ack1c_stat", bus.GPIO_STAT, 8'h00);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
    chk("fill_stat", bus.GPIO_STAT, 8'h23);
    chk("fill_data", bus.GPIO_DATA, 8'h01);
    clear_flags();
    chk("clr_stat", bus.GPIO_STAT, 8'h21);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", bus.GPIO_DATA, 8'(i));
      ack("drain");
    end
    ack("empty_pop");

    send_frame(8'hF0, 1'b1);
    chk("badpar_stat", bus.GPIO_STAT, 8'h04);
    send_frame(8'hF0, 1'b0);
    chk("goodf0_stat", bus.GPIO_STAT, 8'h0D);
    chk("goodf0_data", bus.GPIO_DATA, 8'hF0);
    clear_flags();
    ack("f0");

    send_bits(8'h55, 1'b0, 5, 1'b0);
    tick(TIMEOUT + 40);
    m_ferr = 1;
    chk_all("timeout");
    send_frame(8'h2A, 1'b0);
    chk_all("after_to");
    clear_flags();
    ack("a2a");

    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b0);
    chk_all("full4");
    send_bits(8'h77, 1'b0, 11, 1'b1);
    void'(mq.pop_front());
    mq.push_back(8'h77);
    bus.GPIO_CTRL[0] = 1'b0;
    tick(SYNC + 3);
    chk("simul_stat", bus.GPIO_STAT, 8'h21);
    chk_all("simul");
    for (int i = 0; i < 4; i++) ack("simul_drain");

    send_bits(8'h3C, 1'b0, 5, 1'b0);
    send_frame(8'h11, 1'b0);
    send_bits(8'h99, 1'b0, 4, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("midrst_data", bus.GPIO_DATA, 8'h00);
    chk("midrst_stat", bus.GPIO_STAT, 8'h00);
    mq.delete();
    m_ovf = 0;
    m_ferr = 0;
    rst = 1'b1;
    tick(3);
    send_frame(8'h5A, 1'b0);
    chk_all("post_rst");
    ack("post_rst");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ack("rnd_ack");
      end else if ($urandom_range(0, 7) == 0) begin
        clear_flags();
        chk_all("rnd_clr");
      end else begin
        rb = 8'($urandom);
        send_frame(rb, $urandom_range(0, 9) == 0);
        chk_all("rnd_frame");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
